// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Bundles the request, hopper handshake and status signals of the change
//   dispenser so the block can be connected with a single port.
//   master : the purchase logic / hopper side (drives start, change digits, coin_ack)
//   slave  : the dispenser itself (drives coin offer, status and remaining amount)
//   Signals:
//     start, change_0..3   request and BCD amount (units..thousands)
//     coin_ack             hopper accepted the offered coin
//     coin_valid, coin_code  coin offer and its denomination
//     busy, done, error    payout status
//     rem_0..3             BCD remaining amount (units..thousands)
interface change_dispenser_if;
  logic       start;
  logic [3:0] change_0;
  logic [3:0] change_1;
  logic [3:0] change_2;
  logic [3:0] change_3;
  logic       coin_ack;
  logic       coin_valid;
  logic [2:0] coin_code;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] rem_0;
  logic [3:0] rem_1;
  logic [3:0] rem_2;
  logic [3:0] rem_3;

  modport master (
    output start, change_0, change_1, change_2, change_3, coin_ack,
    input  coin_valid, coin_code, busy, done, error, rem_0, rem_1, rem_2, rem_3
  );

  modport slave (
    input  start, change_0, change_1, change_2, change_3, coin_ack,
    output coin_valid, coin_code, busy, done, error, rem_0, rem_1, rem_2, rem_3
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a 4-digit BCD change amount as 5/10/20/50 coins, one coin per
//   hopper handshake, always choosing the largest coin that still fits.
//   Coin codes: 000=5, 001=10, 011=20, 100=50.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  change_dispenser_if.slave (request, hopper handshake, status, remainder)
//   Parameters:
//     ACK_TIMEOUT  cycles an offer may wait for coin_ack before aborting (>=2)
//     TO_W         width of the timeout counter, must hold ACK_TIMEOUT-1
module change_dispenser #(
  parameter int ACK_TIMEOUT = 1000,
  parameter int TO_W        = 10
) (
  input logic           clk,
  input logic           rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, OFFER, DONE} state_t;

  localparam logic [2:0]      COIN_5  = 3'b000;
  localparam logic [2:0]      COIN_10 = 3'b001;
  localparam logic [2:0]      COIN_20 = 3'b011;
  localparam logic [2:0]      COIN_50 = 3'b100;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [15:0]     rem_q, rem_d;
  logic            coin_valid_q, coin_valid_d;
  logic [2:0]      coin_code_q, coin_code_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            bad_amount;
  logic [2:0]      greedy_code;

  // Removes one coin from a BCD remainder. Under the greedy choice only the
  // 50 coin can need a borrow, and it never underflows the thousands digit.
  function automatic logic [15:0] pay_coin(input logic [15:0] r, input logic [2:0] code);
    logic [3:0] u, t, h, k;
    {k, h, t, u} = r;
    case (code)
      COIN_5:  u = 4'd0;
      COIN_10: t = t - 4'd1;
      COIN_20: t = t - 4'd2;
      default: begin
        if (t >= 4'd5) begin
          t = t - 4'd5;
        end else begin
          t = t + 4'd5;
          if (h == 4'd0) begin
            h = 4'd9;
            k = k - 4'd1;
          end else begin
            h = h - 4'd1;
          end
        end
      end
    endcase
    return {k, h, t, u};
  endfunction

  // A remainder is only payable if every digit is decimal and the units can
  // be covered by the 5 coin.
  assign bad_amount = (rem_q[15:12] > 4'd9) || (rem_q[11:8] > 4'd9) ||
                      (rem_q[7:4] > 4'd9) || (rem_q[3:0] > 4'd9) ||
                      ((rem_q[3:0] != 4'd0) && (rem_q[3:0] != 4'd5));

  assign greedy_code = ((rem_q[15:8] != 8'd0) || (rem_q[7:4] >= 4'd5)) ? COIN_50 :
                       (rem_q[7:4] >= 4'd2) ? COIN_20 :
                       (rem_q[7:4] >= 4'd1) ? COIN_10 : COIN_5;

  // Next-state and registered-output logic. An ack arriving on the same
  // edge as the timeout is checked first so it takes precedence.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    coin_valid_d = coin_valid_q;
    coin_code_d  = coin_code_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    to_cnt_d     = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = {bus.change_3, bus.change_2, bus.change_1, bus.change_0};
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (bad_amount) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (rem_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          coin_code_d  = greedy_code;
          coin_valid_d = 1'b1;
          to_cnt_d     = '0;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        if (bus.coin_ack) begin
          rem_d        = pay_coin(rem_q, coin_code_q);
          coin_valid_d = 1'b0;
          to_cnt_d     = '0;
          state_d      = CALC;
        end else if (to_cnt_q == TO_LAST) begin
          coin_valid_d = 1'b0;
          to_cnt_d     = '0;
          error_d      = 1'b1;
          done_d       = 1'b1;
          state_d      = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        coin_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending offer immediately
  // and suppresses the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      coin_valid_q <= 1'b0;
      coin_code_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_valid_q <= coin_valid_d;
      coin_code_q  <= coin_code_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.coin_valid = coin_valid_q;
  assign bus.coin_code  = coin_code_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.rem_0      = rem_q[3:0];
  assign bus.rem_1      = rem_q[7:4];
  assign bus.rem_2      = rem_q[11:8];
  assign bus.rem_3      = rem_q[15:12];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Drives directed and random payouts into change_dispenser and compares
//   every observed output against a decimal-arithmetic reference model.
module tb_change_dispenser;
  localparam int ACK_TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst;
  int   vectorCount = 0;
  int   errorCount  = 0;

  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single comparison point: counts the vector and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] toBcd(input int amount);
    return {4'(amount / 1000 % 10), 4'(amount / 100 % 10), 4'(amount / 10 % 10), 4'(amount % 10)};
  endfunction

  function automatic int coinValue(input int amount);
    if (amount >= 50) return 50;
    if (amount >= 20) return 20;
    if (amount >= 10) return 10;
    return 5;
  endfunction

  function automatic logic [2:0] coinCode(input int value);
    case (value)
      50:      return 3'b100;
      20:      return 3'b011;
      10:      return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Compares the full visible state; the code only matters while offered.
  task automatic checkAll(input string tag, input bit v, input logic [2:0] code,
                          input bit b, input bit d, input bit e, input logic [15:0] rem);
    checkOutput({tag, ".valid"}, 32'(bus.coin_valid), 32'(v));
    if (v) checkOutput({tag, ".code"}, 32'(bus.coin_code), 32'(code));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(b));
    checkOutput({tag, ".done"}, 32'(bus.done), 32'(d));
    checkOutput({tag, ".error"}, 32'(bus.error), 32'(e));
    checkOutput({tag, ".rem"}, 32'({bus.rem_3, bus.rem_2, bus.rem_1, bus.rem_0}), 32'(rem));
  endtask

  task automatic startPayout(input logic [15:0] digits);
    bus.start = 1'b1;
    {bus.change_3, bus.change_2, bus.change_1, bus.change_0} = digits;
    step();
    bus.start = 1'b0;
  endtask

  // Runs one complete payout. The model works on the decimal amount; with
  // noise set, stray acks and starts are thrown in while the block is busy.
  task automatic applyStimulus(input logic [15:0] digits, input int maxDelay, input bit noise);
    bit valid;
    int amount;
    valid = (digits[15:12] <= 4'd9) && (digits[11:8] <= 4'd9) && (digits[7:4] <= 4'd9) &&
            ((digits[3:0] == 4'd0) || (digits[3:0] == 4'd5));
    amount = 1000 * int'(digits[15:12]) + 100 * int'(digits[11:8]) +
             10 * int'(digits[7:4]) + int'(digits[3:0]);
    startPayout(digits);
    checkAll("calc0", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, digits);
    if (!valid) begin
      if (noise) bus.coin_ack = 1'b1;
      step();
      bus.coin_ack = 1'b0;
      checkAll("bad.done", 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, digits);
      step();
      checkAll("bad.idle", 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, digits);
      return;
    end
    while (amount > 0) begin
      int coin = coinValue(amount);
      int delay;
      if (noise) begin
        bus.coin_ack = 1'($urandom_range(0, 1));
        bus.start    = 1'($urandom_range(0, 1));
        {bus.change_3, bus.change_2, bus.change_1, bus.change_0} = 16'($urandom);
      end
      step();
      bus.coin_ack = 1'b0;
      bus.start    = 1'b0;
      checkAll("offer", 1'b1, coinCode(coin), 1'b1, 1'b0, 1'b0, toBcd(amount));
      delay = $urandom_range(0, maxDelay);
      for (int i = 0; i < delay; i++) begin
        step();
        checkOutput("wait.valid", 32'(bus.coin_valid), 32'd1);
        checkOutput("wait.code", 32'(bus.coin_code), 32'(coinCode(coin)));
      end
      bus.coin_ack = 1'b1;
      step();
      bus.coin_ack = 1'b0;
      amount -= coin;
      checkAll("acked", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, toBcd(amount));
    end
    step();
    checkAll("done", 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    checkAll("idle", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.coin_ack = 1'b0;
    {bus.change_3, bus.change_2, bus.change_1, bus.change_0} = 16'h0000;
    step();
    step();
    checkAll("reset", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    step();

    // Reset while a coin is being offered.
    startPayout(16'h0060);
    step();
    checkAll("pre_rst", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0060);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkAll("mid_rst", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    checkAll("post_rst", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Directed amounts.
    applyStimulus(16'h0035, 0, 1'b0);
    applyStimulus(16'h0125, 0, 1'b0);
    applyStimulus(16'h9995, 0, 1'b0);
    applyStimulus(16'h0000, 0, 1'b0);
    applyStimulus(16'h0013, 0, 1'b0);
    applyStimulus(16'h00A5, 2, 1'b1);

    // Ack withheld for the full timeout.
    startPayout(16'h0060);
    step();
    checkAll("to.offer", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0060);
    repeat (ACK_TIMEOUT - 1) step();
    checkAll("to.last", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 16'h0060);
    step();
    checkAll("to.done", 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 16'h0060);
    step();
    checkAll("to.idle", 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0060);

    // Ack landing on the timeout edge is still an ack.
    startPayout(16'h0060);
    checkOutput("tie.err_clr", 32'(bus.error), 32'd0);
    step();
    repeat (ACK_TIMEOUT - 1) step();
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    checkAll("tie.ack", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0010);
    step();
    checkAll("tie.offer2", 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0010);
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    checkAll("tie.ack2", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    checkAll("tie.done", 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();

    // Random payouts, occasionally with malformed amounts.
    for (int n = 0; n < 24; n++) begin
      int sel = $urandom_range(0, 7);
      if (sel == 0) applyStimulus(16'($urandom), 3, 1'b1);
      else applyStimulus(toBcd(5 * $urandom_range(0, (sel < 6) ? 40 : 1999)), 3, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end
endmodule
